wb_port_arbiter: RTL and testbench



---
 rtl/lc3_wb_pkg.sv | 24 ++
 rtl/rr_pick3.sv | 29 ++
 rtl/wb_port_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_wb_pkg.sv
// Shared types for the writeback write-port arbiter: source-select codes
// and requester indices, also used by writeback decode and the bench.
package lc3_wb_pkg;

  localparam int DW   = 16;
  localparam int RW   = 3;
  localparam int NREQ = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_PC  = 2;

  typedef enum logic [1:0] {
    WSEL_ALU = 2'd0,
    WSEL_MEM = 2'd1,
    WSEL_PC  = 2'd2
  } wsel_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] dr;
  } wb_req_t;

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: search starts at the requester
// after the last grant, in ALU -> MEM -> PC order.
module rr_pick3
  import lc3_wb_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] last_i,
  output logic [NREQ-1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (last_i[REQ_ALU]) begin
      if      (req_i[REQ_MEM]) gnt_o[REQ_MEM] = 1'b1;
      else if (req_i[REQ_PC])  gnt_o[REQ_PC]  = 1'b1;
      else if (req_i[REQ_ALU]) gnt_o[REQ_ALU] = 1'b1;
    end else if (last_i[REQ_MEM]) begin
      if      (req_i[REQ_PC])  gnt_o[REQ_PC]  = 1'b1;
      else if (req_i[REQ_ALU]) gnt_o[REQ_ALU] = 1'b1;
      else if (req_i[REQ_MEM]) gnt_o[REQ_MEM] = 1'b1;
    end else begin
      // PC last (also the reset pointer): ALU has first priority
      if      (req_i[REQ_ALU]) gnt_o[REQ_ALU] = 1'b1;
      else if (req_i[REQ_MEM]) gnt_o[REQ_MEM] = 1'b1;
      else if (req_i[REQ_PC])  gnt_o[REQ_PC]  = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates ALU / MEM-load / PC-link requesters onto the single writeback
// port. Define WB_ARB_RR_EN for round-robin; default is fixed MEM > ALU > PC.
module wb_port_arbiter
  import lc3_wb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [DW-1:0] alu_data,
  input  logic [RW-1:0] alu_dr,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [DW-1:0] mem_data,
  input  logic [RW-1:0] mem_dr,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic [DW-1:0] pc_data,
  input  logic [RW-1:0] pc_dr,
  output logic          enable_writeback,
  output logic [1:0]    W_Control,
  output logic [RW-1:0] wb_dr,
  output logic [DW-1:0] aluout,
  output logic [DW-1:0] memout,
  output logic [DW-1:0] pcout,
  output logic          busy
);

  logic [NREQ-1:0] req_vld, gnt, rdy;
  wb_req_t         req [NREQ];
  wb_req_t         win;
  wsel_e           wsel_d, wsel_q;
  logic            xfer;
  logic            en_q;
  logic [RW-1:0]   dr_q;
  logic [DW-1:0]   aluout_q, memout_q, pcout_q;

  assign req_vld[REQ_ALU] = alu_valid;
  assign req_vld[REQ_MEM] = mem_valid;
  assign req_vld[REQ_PC]  = pc_valid;
  assign req[REQ_ALU]     = '{data: alu_data, dr: alu_dr};
  assign req[REQ_MEM]     = '{data: mem_data, dr: mem_dr};
  assign req[REQ_PC]      = '{data: pc_data,  dr: pc_dr};

`ifdef WB_ARB_RR_EN
  logic [NREQ-1:0] last_q, last_d;

  rr_pick3 u_pick (
    .req_i  (req_vld),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  // Pointer moves only on an actual transfer, never on stall/idle
  assign last_d = xfer ? rdy : last_q;

  always_ff @(posedge clk) begin
    if (rst) last_q <= NREQ'(1) << REQ_PC;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    gnt = '0;
    if      (req_vld[REQ_MEM]) gnt[REQ_MEM] = 1'b1;
    else if (req_vld[REQ_ALU]) gnt[REQ_ALU] = 1'b1;
    else if (req_vld[REQ_PC])  gnt[REQ_PC]  = 1'b1;
  end
`endif

  assign rdy  = gnt & {NREQ{!stall && !rst}};
  assign xfer = |rdy;

  assign alu_ready = rdy[REQ_ALU];
  assign mem_ready = rdy[REQ_MEM];
  assign pc_ready  = rdy[REQ_PC];

  always_comb begin
    win    = req[REQ_ALU];
    wsel_d = WSEL_ALU;
    if (rdy[REQ_MEM]) begin
      win    = req[REQ_MEM];
      wsel_d = WSEL_MEM;
    end else if (rdy[REQ_PC]) begin
      win    = req[REQ_PC];
      wsel_d = WSEL_PC;
    end
  end

  // Select/dr hold when idle so the DR_in mux never sees a stale-X select
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      wsel_q   <= WSEL_ALU;
      dr_q     <= '0;
      aluout_q <= '0;
      memout_q <= '0;
      pcout_q  <= '0;
    end else begin
      en_q <= xfer;
      if (xfer) begin
        wsel_q <= wsel_d;
        dr_q   <= win.dr;
      end
      if (rdy[REQ_ALU]) aluout_q <= win.data;
      if (rdy[REQ_MEM]) memout_q <= win.data;
      if (rdy[REQ_PC])  pcout_q  <= win.data;
    end
  end

  assign enable_writeback = en_q;
  assign busy             = en_q;
  assign W_Control        = wsel_q;
  assign wb_dr            = dr_q;
  assign aluout           = aluout_q;
  assign memout           = memout_q;
  assign pcout            = pcout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(rdy));
      assert (wsel_q != 2'd3);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter; models the writeback register file
// and psr so end-to-end register contents can be checked.
module tb_wb_port_arbiter;
  import lc3_wb_pkg::*;

  logic          clk, rst, stall;
  logic          alu_valid, alu_ready, mem_valid, mem_ready, pc_valid, pc_ready;
  logic [DW-1:0] alu_data, mem_data, pc_data;
  logic [RW-1:0] alu_dr, mem_dr, pc_dr;
  logic          enable_writeback, busy;
  logic [1:0]    W_Control;
  logic [RW-1:0] wb_dr;
  logic [DW-1:0] aluout, memout, pcout;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst), .stall(stall),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data), .alu_dr(alu_dr),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data), .mem_dr(mem_dr),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_data(pc_data), .pc_dr(pc_dr),
    .enable_writeback(enable_writeback), .W_Control(W_Control), .wb_dr(wb_dr),
    .aluout(aluout), .memout(memout), .pcout(pcout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [1:0]    sel;
    logic [RW-1:0] dr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [DW-1:0] rf [8];
  logic [2:0]    psr;
  logic [2:0]    rdy_v;

  task automatic push_wr(input logic [1:0] sel, input logic [RW-1:0] dr, input logic [DW-1:0] data);
    exp_t e;
    e.due = cyc + 1; e.sel = sel; e.dr = dr; e.data = data;
    exp_q.push_back(e);
  endtask

  // Register-file model sampled before the edge, then one edge, then the
  // write-port check for the new cycle against the scoreboard.
  task automatic tick();
    logic [DW-1:0] v;
    exp_t e;
    logic [DW-1:0] bus;
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] = '0;
      psr = 3'b010;
    end else if (enable_writeback === 1'b1) begin
      v = (W_Control == 2'd0) ? aluout : (W_Control == 2'd1) ? memout : pcout;
      rf[wb_dr] = v;
      psr = v[15] ? 3'b100 : (v == 16'h0) ? 3'b010 : 3'b001;
    end
    @(posedge clk);
    cyc++;
    #1;
    total++;
    if (busy !== enable_writeback) begin
      bad++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, enable_writeback);
    end
    total++;
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      bus = (e.sel == 2'd0) ? aluout : (e.sel == 2'd1) ? memout : pcout;
      if (enable_writeback !== 1'b1 || W_Control !== e.sel || wb_dr !== e.dr || bus !== e.data) begin
        bad++;
        $display("FAIL write cyc=%0d got en=%b sel=%0d dr=%0d data=%h want en=1 sel=%0d dr=%0d data=%h",
                 cyc, enable_writeback, W_Control, wb_dr, bus, e.sel, e.dr, e.data);
      end
    end else if (enable_writeback !== 1'b0) begin
      bad++; $display("FAIL idle cyc=%0d got en=%b want en=0", cyc, enable_writeback);
    end
  endtask

  task automatic clear_req();
    alu_valid = 0; mem_valid = 0; pc_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; clear_req();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; clear_req();
    alu_valid = 1; alu_data = 16'hdead; alu_dr = 3'd1;
    mem_data = '0; mem_dr = '0; pc_data = '0; pc_dr = '0;
    #1;
    total++;
    if ({pc_ready, mem_ready, alu_ready} !== 3'b000) begin
      bad++; $display("FAIL ready_in_rst got=%b want=000", {pc_ready, mem_ready, alu_ready});
    end
    tick(); tick();
    rst = 0; clear_req();
    #1;
    total++;
    if ({enable_writeback, busy, W_Control, wb_dr, aluout, memout, pcout} !== '0) begin
      bad++; $display("FAIL reset_outs got en=%b sel=%0d dr=%0d a=%h m=%h p=%h want all 0",
                      enable_writeback, W_Control, wb_dr, aluout, memout, pcout);
    end
    tick();
  endtask

  task automatic test_single_alu();
    alu_valid = 1; alu_data = 16'h1234; alu_dr = 3'd3;
    #1;
    rdy_v = {pc_ready, mem_ready, alu_ready};
    total++;
    if (rdy_v !== 3'b001) begin
      bad++; $display("FAIL single_ready got=%b want=001", rdy_v);
    end
    push_wr(WSEL_ALU, 3'd3, 16'h1234);
    tick();
    clear_req();
    tick();
    total++;
    if (rf[3] !== 16'h1234 || psr !== 3'b001) begin
      bad++; $display("FAIL single_rf got r3=%h psr=%b want r3=1234 psr=001", rf[3], psr);
    end
    total++;
    if (W_Control !== 2'd0 || wb_dr !== 3'd3) begin
      bad++; $display("FAIL single_hold got sel=%0d dr=%0d want sel=0 dr=3", W_Control, wb_dr);
    end
  endtask

  task automatic test_all_valid();
    int seq[6];
`ifdef WB_ARB_RR_EN
    seq = '{0, 1, 2, 0, 1, 2};
`else
    seq = '{1, 1, 1, 1, 1, 1};
`endif
    do_reset();
    alu_valid = 1; alu_data = 16'h0aaa; alu_dr = 3'd1;
    mem_valid = 1; mem_data = 16'h8bbb; mem_dr = 3'd2;
    pc_valid  = 1; pc_data  = 16'h0ccc; pc_dr  = 3'd4;
    for (int i = 0; i < 6; i++) begin
      #1;
      rdy_v = {pc_ready, mem_ready, alu_ready};
      total++;
      if (rdy_v !== (3'b001 << seq[i])) begin
        bad++; $display("FAIL all_valid_ready[%0d] got=%b want=%b", i, rdy_v, 3'b001 << seq[i]);
      end
      case (seq[i])
        0:       push_wr(WSEL_ALU, 3'd1, 16'h0aaa);
        1:       push_wr(WSEL_MEM, 3'd2, 16'h8bbb);
        default: push_wr(WSEL_PC,  3'd4, 16'h0ccc);
      endcase
      tick();
    end
    clear_req();
    tick();
  endtask

  task automatic test_stall();
    alu_valid = 1; alu_data = 16'h0042; alu_dr = 3'd0;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++; $display("FAIL stall_pre_ready got=%b want=1", alu_ready);
    end
    push_wr(WSEL_ALU, 3'd0, 16'h0042);
    tick();
    // ALU write registered above must still issue during the stall
    stall = 1; alu_valid = 0;
    mem_valid = 1; mem_data = 16'h8000; mem_dr = 3'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({pc_ready, mem_ready, alu_ready} !== 3'b000) begin
        bad++; $display("FAIL stall_ready[%0d] got=%b want=000", i, {pc_ready, mem_ready, alu_ready});
      end
      tick();
    end
    stall = 0;
    #1;
    total++;
    if (mem_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release got=%b want=1", mem_ready);
    end
    push_wr(WSEL_MEM, 3'd5, 16'h8000);
    tick();
    clear_req();
    tick();
    total++;
    if (rf[5] !== 16'h8000 || psr !== 3'b100) begin
      bad++; $display("FAIL stall_rf got r5=%h psr=%b want r5=8000 psr=100", rf[5], psr);
    end
    total++;
    if (W_Control !== 2'd1 || wb_dr !== 3'd5 || aluout !== 16'h0042) begin
      bad++; $display("FAIL stall_hold got sel=%0d dr=%0d alu=%h want sel=1 dr=5 alu=0042",
                      W_Control, wb_dr, aluout);
    end
  endtask

  task automatic test_same_dr();
    do_reset();
    alu_valid = 1; alu_data = 16'h0001; alu_dr = 3'd7;
    pc_valid  = 1; pc_data  = 16'h3005; pc_dr  = 3'd7;
    #1;
    total++;
    if ({pc_ready, mem_ready, alu_ready} !== 3'b001) begin
      bad++; $display("FAIL same_dr_first got=%b want=001", {pc_ready, mem_ready, alu_ready});
    end
    push_wr(WSEL_ALU, 3'd7, 16'h0001);
    tick();
    alu_valid = 0;
    #1;
    total++;
    if ({pc_ready, mem_ready, alu_ready} !== 3'b100) begin
      bad++; $display("FAIL same_dr_second got=%b want=100", {pc_ready, mem_ready, alu_ready});
    end
    push_wr(WSEL_PC, 3'd7, 16'h3005);
    tick();
    clear_req();
    tick();
    total++;
    if (rf[7] !== 16'h3005 || psr !== 3'b001) begin
      bad++; $display("FAIL same_dr_rf got r7=%h psr=%b want r7=3005 psr=001", rf[7], psr);
    end
  endtask

  task automatic test_rst_pending();
    do_reset();
    alu_valid = 1; alu_data = 16'h5555; alu_dr = 3'd2;
    #1;
    push_wr(WSEL_ALU, 3'd2, 16'h5555);
    tick();
    rst = 1; alu_valid = 0;
    mem_valid = 1; mem_data = 16'h7777; mem_dr = 3'd6;
    #1;
    total++;
    if (mem_ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready got=%b want=0", mem_ready);
    end
    tick();
    rst = 0; clear_req();
    total++;
    if (aluout !== 16'h0 || W_Control !== 2'd0 || wb_dr !== 3'd0) begin
      bad++; $display("FAIL rst_clear got a=%h sel=%0d dr=%0d want 0", aluout, W_Control, wb_dr);
    end
    total++;
    if (rf[2] !== 16'h0) begin
      bad++; $display("FAIL rst_rf got r2=%h want 0000", rf[2]);
    end
    // Pointer back at reset value: RR picks ALU, fixed picks MEM
    alu_valid = 1; alu_data = 16'h0111; alu_dr = 3'd1;
    mem_valid = 1; mem_data = 16'h0222; mem_dr = 3'd2;
    pc_valid  = 1; pc_data  = 16'h0333; pc_dr  = 3'd3;
    #1;
    rdy_v = {pc_ready, mem_ready, alu_ready};
    total++;
`ifdef WB_ARB_RR_EN
    if (rdy_v !== 3'b001) begin
      bad++; $display("FAIL rst_ptr got=%b want=001", rdy_v);
    end
    push_wr(WSEL_ALU, 3'd1, 16'h0111);
`else
    if (rdy_v !== 3'b010) begin
      bad++; $display("FAIL rst_ptr got=%b want=010", rdy_v);
    end
    push_wr(WSEL_MEM, 3'd2, 16'h0222);
`endif
    tick();
    clear_req();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_all_valid();
    test_stall();
    test_same_dr();
    test_rst_pending();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
